// File: rtl/hv_accum_ctrl_if.sv
// Control, element stream and dual-port memory signals of the hypervector accumulate controller.
interface hv_accum_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic                  mode;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH:0]   sat_count;

  modport slave (
    input  start, mode, base_addr, length, in_valid, in_data, rd_data,
    output in_ready, rd_addr, wr_addr, wr_data, wr_en, busy, done, sat_count
  );

  modport master (
    output start, mode, base_addr, length, in_valid, in_data, rd_data,
    input  in_ready, rd_addr, wr_addr, wr_data, wr_en, busy, done, sat_count
  );
endinterface

// File: rtl/hv_accum_ctrl.sv
// Saturating read-modify-write bundler (and region clear) over a dual-port memory.
// One element per cycle, write lands 1 cycle after the handshake; in_valid gaps just stall.
module hv_accum_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  hv_accum_ctrl_if.slave bus
);
  localparam int                       LW      = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0]      DEPTH_C = LW'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0]      ONE_C   = LW'(1);
  localparam logic [DATA_WIDTH-1:0]    MAX_C   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0]    MIN_C   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_CLEAR, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [ADDR_WIDTH:0]   sat_q, sat_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH:0]   sum_w;
  logic                  sat_hit;
  logic [DATA_WIDTH-1:0] sum_sat;
  logic                  last_idx;

  // One extra bit of sum: overflow shows up as disagreement between the top two bits.
  assign cur_addr = base_q + idx_q[ADDR_WIDTH-1:0];
  assign sum_w    = {bus.rd_data[DATA_WIDTH-1], bus.rd_data} + {bus.in_data[DATA_WIDTH-1], bus.in_data};
  assign sat_hit  = sum_w[DATA_WIDTH] != sum_w[DATA_WIDTH-1];
  assign sum_sat  = sat_hit ? (sum_w[DATA_WIDTH] ? MIN_C : MAX_C) : sum_w[DATA_WIDTH-1:0];
  assign last_idx = idx_q == (len_q - ONE_C);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    idx_d     = idx_q;
    sat_d     = sat_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          base_d = bus.base_addr;
          len_d  = (bus.length > DEPTH_C) ? DEPTH_C : bus.length;
          idx_d  = '0;
          sat_d  = '0;
          if (bus.length == '0)  state_d = S_DONE;
          else if (bus.mode)     state_d = S_CLEAR;
          else                   state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        rd_addr_d = cur_addr;
        if (bus.in_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cur_addr;
          wr_data_d = sum_sat;
          idx_d     = idx_q + ONE_C;
          if (sat_hit) sat_d = sat_q + ONE_C;
          if (last_idx) state_d = S_DRAIN;
        end
      end
      S_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cur_addr;
        wr_data_d = '0;
        idx_d     = idx_q + ONE_C;
        if (last_idx) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_IDLE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      sat_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      sat_q     <= sat_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Outside ACCUM the read port parks on the last address it used.
  assign bus.in_ready  = state_q == S_ACCUM;
  assign bus.rd_addr   = (state_q == S_ACCUM) ? cur_addr : rd_addr_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = state_q != S_IDLE;
  assign bus.done      = (state_q == S_DRAIN) || (state_q == S_DONE);
  assign bus.sat_count = sat_q;
endmodule

// File: doc/hv_accum_ctrl.md
Name: hv_accum_ctrl

Overview:
- Read-modify-write controller that bundles (element-wise adds) an incoming hypervector stream into a class-hypervector region of memory_double.
- Drives memory_double port 0 as a read-only port: address_0 = rd_addr, we_0 tied 0 at top level, data_0_out returns as rd_data.
- Drives memory_double port 1 as a write-only port: address_1 = wr_addr, data_1_in = wr_data, we_1 = wr_en.
- Also provides a clear mode that zeroes a region before training.

Parameters:
- DATA_WIDTH, 16, element width (two's complement signed); matches the memory word width.
- ADDR_WIDTH, 8, memory address width.
- RAM_DEPTH, 1 << ADDR_WIDTH, number of memory words.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  pass request; sampled only in IDLE.
- mode  in  1  0 = accumulate, 1 = clear; sampled with start.
- base_addr  in  ADDR_WIDTH  first element address; sampled with start.
- length  in  ADDR_WIDTH+1  element count; sampled with start.
- in_valid  in  1  input element valid.
- in_data  in  DATA_WIDTH  signed input element.
- in_ready  out  1  element accepted when in_valid && in_ready.
- rd_addr  out  ADDR_WIDTH  to address_0.
- rd_data  in  DATA_WIDTH  from data_0_out; combinational, same-cycle.
- wr_addr  out  ADDR_WIDTH  to address_1.
- wr_data  out  DATA_WIDTH  to data_1_in.
- wr_en  out  1  to we_1.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at pass end.
- sat_count  out  ADDR_WIDTH+1  saturation events in the current/last pass.

Behaviour:
- Reset: rst_n low at a clk edge forces IDLE and sets in_ready, wr_en, busy, done, sat_count, wr_addr, wr_data and rd_addr to 0.
  - Reset mid-pass abandons the pass; writes already committed stay in memory; no done pulse.
- States:
  - IDLE: on start, latch base_q, mode_q and len_q = min(length, RAM_DEPTH); clear idx and sat_count.
    - If len_q = 0: next state is DONE.
    - Else: next state is CLEAR (mode = 1) or ACCUM (mode = 0).
    - start in any other state is ignored.
  - ACCUM: in_ready = 1; rd_addr = (base_q + idx) mod RAM_DEPTH, combinational.
    - On each handshake: sum = sign-extended rd_data + in_data, computed at DATA_WIDTH+1 bits, then saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
    - On a clamp, sat_count increments; it never exceeds RAM_DEPTH, so there is no overflow.
    - Next cycle: wr_en = 1, wr_addr = the read address, wr_data = the saturated sum.
    - idx then increments.
    - On the handshake with idx = len_q-1, next state is DRAIN.
    - Cycles without in_valid produce wr_en = 0 on the next cycle; there is no penalty otherwise.
  - CLEAR: in_ready = 0.
    - Each cycle, register wr_en = 1, wr_addr = base_q + idx, wr_data = 0, then increment idx.
    - After idx = len_q-1 is issued, next state is DRAIN.
  - DRAIN: the final registered write is presented (wr_en = 1); done = 1 in this cycle; next state is IDLE.
  - DONE (len_q = 0 only): done = 1, no writes; next state is IDLE.
- Latency and throughput:
  - One element per cycle.
  - Write occurs exactly 1 cycle after the handshake.
  - Pass duration from start sampled to done: len_q + 1 cycles with no gaps.
- Hazards:
  - Addresses within a pass are distinct (len_q ≤ RAM_DEPTH), so no read-after-write forwarding is needed.
  - A new start is accepted at the earliest one cycle after done, so the final write is committed before the next pass reads.
- Wrap-around: address arithmetic is modulo RAM_DEPTH; base_addr + length crossing RAM_DEPTH wraps to 0.
- rd_addr holds its last value outside ACCUM; wr_en is 0 in IDLE and DONE.

Test Plan:
- Clear, then accumulate:
  - Clear base 0, length 4 -> writes 0 to addrs 0..3, done 5 cycles after start.
  - Then accumulate in_data 5, -3, 7, 1 -> mem[0..3] = 5, -3, 7, 1.
  - Repeat the same pass -> mem[0..3] = 10, -6, 14, 2, sat_count = 0.
- Saturation:
  - mem[10] = 32760, mem[11] = -32760; accumulate base 10, length 2, data 100, -100 -> mem[10] = 32767, mem[11] = -32768, sat_count = 2.
- Wrap-around: clear base 254, length 4 -> wr_addr sequence 254, 255, 0, 1.
- Back-pressure: in_valid pattern 1,0,0,1,1 for length 3 -> exactly 3 writes, each one cycle after its handshake; done after the third write.
- Boundaries:
  - length 0 -> done 1 cycle after start, no wr_en.
  - length 300 -> clamped to 256 writes.
  - start while busy -> ignored.
- Reset and back-to-back passes:
  - rst_n low after 2 of 4 accumulates -> next cycle IDLE, busy = 0, no done; mem holds the 2 updated words only.
  - Back-to-back passes to the same region -> the second pass reads the first pass's last write correctly.
